// File: rtl/counter.sv
// W-bit synchronous up/down counter with count enable.
// Wraps silently modulo 2^W in both directions; cnt is a plain register.
module counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] cnt
);

  // Unsigned W-bit step; the carry/borrow out is dropped, giving the wrap.
  function automatic logic [W-1:0] step_cnt(input logic [W-1:0] cur, input logic dir);
    if (dir) return cur + W'(1);
    else     return cur - W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= step_cnt(cnt, up);
    end
  end

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: W=8 and W=4 instances share clk/rst_n.
// The driver queues expected values; a negedge monitor pops and compares.
module tb_counter;

  typedef struct {
    logic       is4;
    logic [7:0] exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, en4, up4;
  logic [7:0] cnt;
  logic [3:0] cnt4;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic [7:0] m8;

  always #5 clk = ~clk;

  counter #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .en(en),  .up(up),  .cnt(cnt));
  counter #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .en(en4), .up(up4), .cnt(cnt4));

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Each entry was pushed before the edge that produces it, so the next
  // negedge after the push is the right time to look at it.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.is4) chk("cnt4", {4'b0, cnt4}, e.exp);
      else       chk("cnt8", cnt, e.exp);
    end
  end

  task automatic step8(input logic e, input logic u, input logic [7:0] exp);
    exp_t t;
    @(negedge clk); #1;
    en = e; up = u; en4 = 1'b0; up4 = 1'b0;
    t.is4 = 1'b0; t.exp = exp;
    q.push_back(t);
  endtask

  task automatic step4(input logic e, input logic u, input logic [3:0] exp);
    exp_t t;
    @(negedge clk); #1;
    en = 1'b0; up = 1'b0; en4 = e; up4 = u;
    t.is4 = 1'b1; t.exp = {4'b0, exp};
    q.push_back(t);
  endtask

  initial begin
    logic e, u;
    rst_n = 1'b0; en = 1'b1; up = 1'b1; en4 = 1'b1; up4 = 1'b1;
    #3;
    chk("reset_cnt8", cnt, 8'd0);
    chk("reset_cnt4", {4'b0, cnt4}, 8'd0);
    #6;
    // Edge at 5 ns passed with en=1 while held in reset.
    chk("reset_hold_cnt8", cnt, 8'd0);
    en = 1'b0; en4 = 1'b0;
    #3 rst_n = 1'b1;

    // Count up 1..10
    for (int i = 1; i <= 10; i++) step8(1'b1, 1'b1, 8'(i));
    // Count down 9..0
    for (int i = 9; i >= 0; i--) step8(1'b1, 1'b0, 8'(i));
    // Hold with toggling direction
    for (int i = 0; i < 10; i++) step8(1'b0, 1'(i), 8'd0);
    // Wrap both ways at W=8 and W=4
    step8(1'b1, 1'b0, 8'd255);
    step8(1'b1, 1'b1, 8'd0);
    step4(1'b1, 1'b0, 4'd15);
    step4(1'b0, 1'b1, 4'd15);
    step4(1'b1, 1'b1, 4'd0);
    // Up to 37, then hold there
    for (int i = 1; i <= 37; i++) step8(1'b1, 1'b1, 8'(i));
    for (int i = 0; i < 3; i++)   step8(1'b0, 1'b0, 8'd37);

    // Asynchronous reset between edges
    @(negedge clk); #1;
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_cnt8", cnt, 8'd0);
    en = 1'b1; up = 1'b1;
    @(posedge clk); #1;
    chk("reset_low_edge_cnt8", cnt, 8'd0);
    en = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    step8(1'b1, 1'b1, 8'd1);

    // Random en/up against a reference model
    m8 = 8'd1;
    for (int i = 0; i < 1000; i++) begin
      e = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      if (e) m8 = u ? 8'((int'(m8) + 1) % 256) : 8'((int'(m8) + 255) % 256);
      step8(e, u, m8);
    end

    repeat (3) @(negedge clk);
    #1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
